// File: rtl/logic_axi4_stream_packet_fifo.sv
// Store-and-forward AXI4-Stream packet FIFO with optional cut-through and an
// oversize policy that either drops the packet or forces it to stream out.
module logic_axi4_stream_packet_fifo #(
   parameter int unsigned TDATA_BYTES   = 4,
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned CUT_THROUGH   = 0,
   parameter int unsigned DROP_OVERSIZE = 1
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     rx_tvalid,
   output logic                     rx_tready,
   input  logic [8*TDATA_BYTES-1:0] rx_tdata,
   input  logic [TDATA_BYTES-1:0]   rx_tkeep,
   input  logic                     rx_tlast,
   output logic                     tx_tvalid,
   input  logic                     tx_tready,
   output logic [8*TDATA_BYTES-1:0] tx_tdata,
   output logic [TDATA_BYTES-1:0]   tx_tkeep,
   output logic                     tx_tlast,
   output logic [$clog2(DEPTH):0]   packets,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     dropped
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned MW = 8 * TDATA_BYTES + TDATA_BYTES + 1;

   typedef logic [AW:0] ptr_t;
   typedef enum logic [0:0] {WrStore, WrDrop} wr_state_t;

   localparam ptr_t DEPTH_P = ptr_t'(DEPTH);
   localparam ptr_t CT_P    = ptr_t'(CUT_THROUGH);
   localparam ptr_t ONE     = ptr_t'(1);

   logic [MW-1:0] mem [DEPTH];

   wr_state_t     state_q, state_d;
   ptr_t          wr_ptr_q, wr_ptr_d;
   ptr_t          commit_ptr_q, commit_ptr_d;
   ptr_t          rd_ptr_q, rd_ptr_d;
   ptr_t          packets_q, packets_d;
   ptr_t          level_q, level_d;
   logic          streaming_q, streaming_d;
   logic          dropped_q, dropped_d;
   logic          tx_valid_q;
   logic [MW-1:0] tx_q;

   logic full, accept, wr_en, commit, start_stream, stream_now, oversize;
   logic can_read, rd_en, tx_last_pop;

   assign full        = (level_q == DEPTH_P);
   assign rx_tready   = !areset && ((state_q == WrStore && !full) || state_q == WrDrop);
   assign accept      = rx_tvalid && rx_tready;
   assign wr_en       = accept && (state_q == WrStore);
   assign commit      = wr_en && rx_tlast;

   // Evaluated combinationally so the first cut-through read issues in the
   // cycle the threshold becomes visible, not one cycle later.
   assign start_stream = (CUT_THROUGH != 0) && (rd_ptr_q == commit_ptr_q) &&
                         (ptr_t'(wr_ptr_q - commit_ptr_q) >= CT_P);
   assign stream_now   = streaming_q || start_stream;
   assign oversize     = wr_en && !rx_tlast && !stream_now &&
                         (ptr_t'(wr_ptr_q + ONE - commit_ptr_q) == DEPTH_P);

   assign can_read    = (rd_ptr_q != commit_ptr_q) || (stream_now && (rd_ptr_q != wr_ptr_q));
   assign rd_en       = can_read && (!tx_valid_q || tx_tready);
   assign tx_last_pop = tx_valid_q && tx_tready && tx_q[MW-1];

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      commit_ptr_d = commit_ptr_q;
      streaming_d  = stream_now;
      dropped_d    = 1'b0;
      unique case (state_q)
         WrStore: begin
            if (wr_en) begin
               wr_ptr_d = wr_ptr_q + ONE;
               if (rx_tlast) begin
                  commit_ptr_d = wr_ptr_q + ONE;
                  // Once committed, the tail is covered by commit_ptr.
                  streaming_d  = 1'b0;
               end else if (oversize) begin
                  if (DROP_OVERSIZE != 0) begin
                     wr_ptr_d  = commit_ptr_q;
                     dropped_d = 1'b1;
                     state_d   = WrDrop;
                  end else begin
                     streaming_d = 1'b1;
                  end
               end
            end
         end
         WrDrop: begin
            if (accept && rx_tlast) state_d = WrStore;
         end
         default: state_d = WrStore;
      endcase
   end

   always_comb begin
      rd_ptr_d  = rd_en ? rd_ptr_q + ONE : rd_ptr_q;
      packets_d = packets_q;
      if (commit && !tx_last_pop) packets_d = packets_q + ONE;
      else if (!commit && tx_last_pop) packets_d = packets_q - ONE;
      level_d = wr_ptr_d - rd_ptr_d;
   end

   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {rx_tlast, rx_tkeep, rx_tdata};
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q      <= WrStore;
         wr_ptr_q     <= '0;
         commit_ptr_q <= '0;
         rd_ptr_q     <= '0;
         packets_q    <= '0;
         level_q      <= '0;
         streaming_q  <= 1'b0;
         dropped_q    <= 1'b0;
         tx_valid_q   <= 1'b0;
         tx_q         <= '0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         packets_q    <= packets_d;
         level_q      <= level_d;
         streaming_q  <= streaming_d;
         dropped_q    <= dropped_d;
         if (rd_en) begin
            tx_valid_q <= 1'b1;
            tx_q       <= mem[rd_ptr_q[AW-1:0]];
         end else if (tx_tready) begin
            tx_valid_q <= 1'b0;
         end
      end
   end

   assign tx_tvalid                      = tx_valid_q;
   assign {tx_tlast, tx_tkeep, tx_tdata} = tx_q;
   assign packets                        = packets_q;
   assign level                          = level_q;
   assign dropped                        = dropped_q;

endmodule
